// File: rtl/axi_fifo_slave.sv
// axi_fifo_slave: AXI4 burst slave exposing a word FIFO at 0x04 and a read-only status word at 0x00.
module axi_fifo_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      s00_axi_aclk,
    input  logic                      s00_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [7:0]                s00_axi_awlen,
    input  logic [2:0]                s00_axi_awsize,
    input  logic [1:0]                s00_axi_awburst,
    input  logic                      s00_axi_awid,
    input  logic                      s00_axi_awvalid,
    output logic                      s00_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                      s00_axi_wlast,
    input  logic                      s00_axi_wvalid,
    output logic                      s00_axi_wready,
    output logic [1:0]                s00_axi_bresp,
    output logic                      s00_axi_bid,
    output logic                      s00_axi_bvalid,
    input  logic                      s00_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [7:0]                s00_axi_arlen,
    input  logic [2:0]                s00_axi_arsize,
    input  logic [1:0]                s00_axi_arburst,
    input  logic                      s00_axi_arvalid,
    output logic                      s00_axi_arready,
    output logic [DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                s00_axi_rresp,
    output logic                      s00_axi_rlast,
    output logic                      s00_axi_rvalid,
    input  logic                      s00_axi_rready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] A_STAT = '0;
    localparam logic [ADDR_WIDTH-1:0] A_FIFO = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DATA} r_state_t;

    logic rst;
    assign rst = s00_axi_aresetn;

    logic unused_ok;
    assign unused_ok = &{1'b0, s00_axi_awsize, s00_axi_awburst, s00_axi_wstrb, s00_axi_arsize, s00_axi_arburst};

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic full, empty, push, pop;
    logic [DATA_WIDTH-1:0] status;

    assign full = count == CW'(FIFO_DEPTH);
    assign empty = count == '0;

    always_comb begin
        status = '0;
        status[0] = empty;
        status[1] = full;
        status[15:8] = 8'(count);
    end

    always_ff @(posedge s00_axi_aclk)
        if (push) mem[wr_ptr] <= s00_axi_wdata;

    always_ff @(posedge s00_axi_aclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    w_state_t w_state, w_next;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [7:0] awlen_q, w_cnt;
    logic awid_q, w_err;
    logic aw_hs, w_beat, w_fifo, w_stat, w_end;

    assign s00_axi_awready = (w_state == W_IDLE) && !rst;
    assign s00_axi_wready = w_state == W_DATA;
    assign s00_axi_bvalid = w_state == W_RESP;
    assign s00_axi_bid = s00_axi_bvalid & awid_q;
    assign s00_axi_bresp = {s00_axi_bvalid & w_err, 1'b0};
    assign aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_beat = s00_axi_wready && s00_axi_wvalid;
    assign w_fifo = awaddr_q == A_FIFO;
    assign w_stat = awaddr_q == A_STAT;
    // A full FIFO still takes the word when the reader frees a slot this cycle.
    assign push = w_beat && w_fifo && (!full || pop);
    assign w_end = w_beat && (s00_axi_wlast || w_cnt == awlen_q);

    always_comb begin
        w_next = w_state == W_IDLE ? (aw_hs ? W_DATA : W_IDLE) :
                 w_state == W_DATA ? (w_end ? W_RESP : W_DATA) :
                 (s00_axi_bready ? W_IDLE : W_RESP);
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (rst) begin
            w_state <= W_IDLE;
            awaddr_q <= '0;
            awlen_q <= '0;
            awid_q <= 1'b0;
            w_cnt <= '0;
            w_err <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                awaddr_q <= s00_axi_awaddr;
                awlen_q <= s00_axi_awlen;
                awid_q <= s00_axi_awid;
                w_cnt <= '0;
            end
            if (w_beat) w_cnt <= w_cnt + 8'd1;
            if (w_beat && (w_fifo ? !push : !w_stat)) w_err <= 1'b1;
            if (s00_axi_bvalid && s00_axi_bready) w_err <= 1'b0;
        end
    end

    r_state_t r_state, r_next;
    logic [ADDR_WIDTH-1:0] araddr_q, r_addr;
    logic [7:0] arlen_q, r_cnt;
    logic ar_hs, r_hs, r_load, r_pop_q;
    logic [DATA_WIDTH-1:0] b_data;
    logic [1:0] b_resp;
    logic b_pop;

    assign s00_axi_arready = (r_state == R_IDLE) && !rst;
    assign s00_axi_rvalid = r_state == R_DATA;
    assign s00_axi_rlast = s00_axi_rvalid && r_cnt == arlen_q;
    assign ar_hs = s00_axi_arvalid && s00_axi_arready;
    assign r_hs = s00_axi_rvalid && s00_axi_rready;
    assign r_load = ar_hs || r_state == R_LOAD;
    assign pop = r_hs && r_pop_q;
    assign r_addr = r_state == R_IDLE ? s00_axi_araddr : araddr_q;

    // Each beat is latched once so rdata/rresp stay put while the master stalls,
    // even if the writer pushes into an empty FIFO meanwhile.
    always_comb begin
        b_data = '0;
        b_resp = 2'b10;
        b_pop = 1'b0;
        if (r_addr == A_FIFO && !empty) begin
            b_data = mem[rd_ptr];
            b_resp = 2'b00;
            b_pop = 1'b1;
        end else if (r_addr == A_STAT) begin
            b_data = status;
            b_resp = 2'b00;
        end
    end

    always_comb begin
        r_next = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) :
                 r_state == R_LOAD ? R_DATA :
                 (s00_axi_rready ? (s00_axi_rlast ? R_IDLE : R_LOAD) : R_DATA);
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (rst) begin
            r_state <= R_IDLE;
            araddr_q <= '0;
            arlen_q <= '0;
            r_cnt <= '0;
            r_pop_q <= 1'b0;
            s00_axi_rdata <= '0;
            s00_axi_rresp <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                araddr_q <= s00_axi_araddr;
                arlen_q <= s00_axi_arlen;
                r_cnt <= '0;
            end
            if (r_load) begin
                s00_axi_rdata <= b_data;
                s00_axi_rresp <= b_resp;
                r_pop_q <= b_pop;
            end
            if (r_hs) r_cnt <= r_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_axi_fifo_slave.sv
// tb_axi_fifo_slave: directed bench for the AXI FIFO mailbox; drives and samples on the falling edge.
module tb_axi_fifo_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] awaddr = '0, araddr = '0;
    logic [7:0] awlen = '0, arlen = '0;
    logic [2:0] awsize = 3'b010, arsize = 3'b010;
    logic [1:0] awburst = 2'b01, arburst = 2'b01;
    logic awid = 1'b0, awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = 4'hf;
    logic awready, wready, bid, bvalid, arready, rlast, rvalid;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;

    int checks = 0;
    int failures = 0;
    logic [31:0] wd [0:31];
    logic [31:0] rd_data [0:31];
    logic [1:0] rd_resp [0:31];
    logic rd_last [0:31];
    logic [1:0] b_resp;
    logic b_id;

    always #5 clk = ~clk;

    axi_fifo_slave dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst),
        .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen), .s00_axi_awsize(awsize),
        .s00_axi_awburst(awburst), .s00_axi_awid(awid), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wlast(wlast), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bid(bid), .s00_axi_bvalid(bvalid),
        .s00_axi_bready(bready), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen),
        .s00_axi_arsize(arsize), .s00_axi_arburst(arburst), .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rlast(rlast), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic axi_wr(input logic [5:0] a, input int n);
        int t;
        @(negedge clk);
        awaddr = a; awlen = 8'(n - 1); awid = 1'b1; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("aw_timeout", 0, 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            wdata = wd[i]; wlast = (i == n - 1); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 100) begin @(negedge clk); t++; end
            if (t >= 100) check("w_timeout", 0, 1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1; b_resp = 2'b11; b_id = 1'b0;
        t = 0;
        while (!bvalid && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("b_timeout", 0, 1);
        b_resp = bresp; b_id = bid;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [5:0] a, input int n);
        int t;
        @(negedge clk);
        araddr = a; arlen = 8'(n - 1); arvalid = 1'b1;
        t = 0;
        while (!arready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("ar_timeout", 0, 1);
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!rvalid && t < 100) begin @(negedge clk); t++; end
            if (t >= 100) check("r_timeout", 0, 1);
            rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast;
            @(negedge clk);
        end
        rready = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic [31:0] exp);
        axi_rd(6'h00, 1);
        check(tag, rd_data[0], exp);
        check({tag, "_resp"}, {30'd0, rd_resp[0]}, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_words [0:5];
        int bad;
        exp_words[0] = 32'hAAAAAAAA; exp_words[1] = 32'hBBBBBBBB; exp_words[2] = 32'hCCCCCCCC;
        exp_words[3] = 32'hDDDDDDDD; exp_words[4] = 32'hEEEEEEEE; exp_words[5] = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        check("rst_ctl", {24'd0, awready, arready, wready, bvalid, rvalid, rlast, bid, 1'b0}, 32'd0);
        check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            wd[0] = exp_words[i];
            axi_wr(6'h04, 1);
            check("wr6_b", {29'd0, b_resp, b_id}, 32'd1);
        end
        chk_status("status6", 32'h0000_0600);

        for (int i = 0; i < 5; i++) begin
            axi_rd(6'h04, 1);
            check("rd5_data", rd_data[0], exp_words[i]);
            check("rd5_resp_last", {29'd0, rd_resp[0], rd_last[0]}, 32'd1);
        end
        chk_status("status1", 32'h0000_0100);

        wd[0] = 32'hABABABAB; wd[1] = 32'hCDCDCDCD; wd[2] = 32'hEFEFEFEF;
        axi_wr(6'h04, 3);
        check("burst_b", {29'd0, b_resp, b_id}, 32'd1);
        chk_status("status4", 32'h0000_0400);
        axi_rd(6'h04, 1);
        check("drain_f", rd_data[0], 32'hFFFFFFFF);
        axi_rd(6'h04, 3);
        check("burst_d0", rd_data[0], 32'hABABABAB);
        check("burst_d1", rd_data[1], 32'hCDCDCDCD);
        check("burst_d2", rd_data[2], 32'hEFEFEFEF);
        check("burst_last", {29'd0, rd_last[0], rd_last[1], rd_last[2]}, 32'd1);
        check("burst_resp", {26'd0, rd_resp[0], rd_resp[1], rd_resp[2]}, 32'd0);

        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            wd[0] = 32'h1000_0000 + i;
            axi_wr(6'h04, 1);
            if (b_resp != 2'b00) bad++;
        end
        check("fill16_okay", bad, 0);
        wd[0] = 32'h1000_0011;
        axi_wr(6'h04, 1);
        check("overflow_b", {30'd0, b_resp}, 32'd2);
        chk_status("status_full", 32'h0000_1002);
        axi_rd(6'h04, 16);
        for (int i = 0; i < 16; i++) check("drain16", rd_data[i], 32'h1000_0001 + i);
        check("drain16_last", {30'd0, rd_last[0], rd_last[15]}, 32'd1);

        axi_rd(6'h04, 1);
        check("empty_rd", {rd_data[0][29:0], rd_resp[0]}, 32'd2);
        chk_status("status_empty", 32'h0000_0001);
        wd[0] = 32'h5555_5555;
        axi_wr(6'h20, 1);
        check("unmap_wr", {30'd0, b_resp}, 32'd2);
        axi_rd(6'h20, 1);
        check("unmap_rd", {rd_data[0][29:0], rd_resp[0]}, 32'd2);
        chk_status("status_unmap", 32'h0000_0001);

        @(negedge clk);
        awaddr = 6'h04; awlen = 8'd2; awid = 1'b1; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wdata = 32'h1111_1111; wvalid = 1'b1; wlast = 1'b0;
        @(negedge clk);
        wvalid = 1'b0; rst = 1'b1; bready = 1'b1;
        @(negedge clk);
        check("midrst_ctl", {24'd0, awready, arready, wready, bvalid, rvalid, rlast, bid, 1'b0}, 32'd0);
        check("midrst_data", {rdata[27:0], bresp, rresp}, 32'd0);
        rst = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bvalid) bad++;
        end
        check("midrst_no_b", bad, 0);
        bready = 1'b0;
        chk_status("status_midrst", 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
